// File: rtl/mem_fu_sched.sv
// Memory FU issue steering and single-slot CDB completion arbitration.
// Build option: define MEM_SCHED_RR_EN for round-robin completion; fixed priority otherwise.
package mem_fu_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  op;
    logic [5:0]  dest_tag;
    logic [31:0] imm;
  } FUNC_UNIT_PACKET;

  typedef struct packed {
    logic        valid;
    logic [31:0] value;
    logic [5:0]  dest_tag;
  } FUNC_OUTPUT;
endpackage

module mem_fu_sched
  import mem_fu_pkg::*;
#(
  parameter int NUM_FU = 2,
  parameter int CNT_W  = $clog2(NUM_FU + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  FUNC_UNIT_PACKET              issue_instr,
  output logic                         issue_stall,
  input  logic [NUM_FU-1:0]            fu_ready,
  input  FUNC_OUTPUT [NUM_FU-1:0]      fu_out,
  output FUNC_UNIT_PACKET [NUM_FU-1:0] fu_instr,
  output logic [NUM_FU-1:0]            fu_sel,
  input  logic                         cdb_ready,
  output FUNC_OUTPUT                   cdb_out,
  output logic [CNT_W-1:0]             busy_cnt
);
  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic              issue_found;
  logic [IDX_W-1:0]  issue_idx;
  logic              issue_accept;
  logic [NUM_FU-1:0] cand;
  logic [NUM_FU-1:0] drain_mask;
  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant;
  FUNC_OUTPUT        cdb_next;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_ready[i] && !issue_found) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_accept = !reset && !squash && issue_instr.valid && issue_found;
  assign issue_stall  = !reset && !squash && issue_instr.valid && !issue_found;

  // Every FU sees the issue packet; only the steered target gets valid.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_instr[i]       = issue_instr;
      fu_instr[i].valid = issue_accept && (issue_idx == IDX_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      cand[i]       = fu_out[i].valid && !fu_ready[i];
      drain_mask[i] = fu_out[i].valid;
    end
  end

`ifdef MEM_SCHED_RR_EN
  logic [IDX_W-1:0] rr_ptr;

  always_comb begin
    int j;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_FU) j = j - NUM_FU;
      if (cand[j] && !grant_found) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end
`else
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (cand[i] && !grant_found) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
  end
`endif

  assign grant = !reset && !squash && cdb_ready && grant_found;

  // Squash acks every FU holding a result so the whole bank drains at once.
  always_comb begin
    fu_sel = '0;
    if (!reset) begin
      if (squash)     fu_sel = drain_mask;
      else if (grant) fu_sel[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    cdb_next = '0;
    if (grant) begin
      cdb_next       = fu_out[grant_idx];
      cdb_next.valid = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_out  <= '0;
      busy_cnt <= '0;
    end else if (squash) begin
      cdb_out  <= '0;
      busy_cnt <= '0;
    end else begin
      cdb_out  <= cdb_next;
      busy_cnt <= busy_cnt + CNT_W'(issue_accept) - CNT_W'(grant);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (busy_cnt == CNT_W'($countones(~fu_ready)));
      assert (busy_cnt <= CNT_W'(NUM_FU));
      assert (!(grant && !issue_accept && busy_cnt == '0));
      assert (!(issue_accept && !grant && busy_cnt == CNT_W'(NUM_FU)));
    end
  end
endmodule

// File: tb/tb_mem_fu_sched.sv
// Self-checking bench for mem_fu_sched: directed vector table, async-reset sequence, random run.
module tb_mem_fu_sched;
  import mem_fu_pkg::*;

  localparam int N  = 2;
  localparam int CW = $clog2(N + 1);

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    squash = 1'b0;
  FUNC_UNIT_PACKET         issue_instr;
  logic                    issue_stall;
  logic [N-1:0]            fu_ready;
  FUNC_OUTPUT [N-1:0]      fu_out;
  FUNC_UNIT_PACKET [N-1:0] fu_instr;
  logic [N-1:0]            fu_sel;
  logic                    cdb_ready = 1'b0;
  FUNC_OUTPUT              cdb_out;
  logic [CW-1:0]           busy_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_fu_sched #(.NUM_FU(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .squash      (squash),
    .issue_instr (issue_instr),
    .issue_stall (issue_stall),
    .fu_ready    (fu_ready),
    .fu_out      (fu_out),
    .fu_instr    (fu_instr),
    .fu_sel      (fu_sel),
    .cdb_ready   (cdb_ready),
    .cdb_out     (cdb_out),
    .busy_cnt    (busy_cnt)
  );

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        cr;
    logic        sq;
    logic        stall;
    logic [1:0]  imask;
    logic [1:0]  sel;
    int          cnt;
    logic        cv;
  } vec_t;

  // Behavioural FU bank + scheduler model: which FUs hold results, and what they hold.
  logic [N-1:0] m_busy;
  logic [31:0]  m_val [N];
  logic [5:0]   m_tag [N];
  int           m_last;
  logic         e_cv;
  logic [31:0]  e_val;
  logic [5:0]   e_tag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = '0;
    m_last = N - 1;
    e_cv   = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_val[i] = '0;
      m_tag[i] = '0;
    end
  endtask

  task automatic apply_fu();
    for (int i = 0; i < N; i++) begin
      fu_ready[i]          = ~m_busy[i];
      fu_out[i].valid      = m_busy[i];
      fu_out[i].value      = m_val[i];
      fu_out[i].dest_tag   = m_tag[i];
    end
  endtask

  task automatic drive_issue(input logic iv, input logic [31:0] pc);
    issue_instr.valid    = iv;
    issue_instr.pc       = pc;
    issue_instr.op       = pc[3:0];
    issue_instr.dest_tag = pc[7:2];
    issue_instr.imm      = ~pc;
  endtask

  // One clock: drive, check combinational outputs, advance, check registered outputs.
  task automatic step(input vec_t v, input bit hand);
    int           t;
    int           g;
    int           j;
    logic         acc;
    logic         exp_stall;
    logic [N-1:0] exp_mask;
    logic [N-1:0] exp_sel;
    logic [N-1:0] act_mask;
    drive_issue(v.iv, v.pc);
    cdb_ready = v.cr;
    squash    = v.sq;
    apply_fu();
    #1;
    t = -1;
    for (int i = 0; i < N; i++) if (!m_busy[i] && t < 0) t = i;
    acc = v.iv && (t >= 0) && !v.sq;
    g = -1;
    if (v.cr && !v.sq) begin
`ifdef MEM_SCHED_RR_EN
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (m_busy[j] && g < 0) g = j;
      end
`else
      for (int i = 0; i < N; i++) if (m_busy[i] && g < 0) g = i;
`endif
    end
    exp_stall = v.iv && (t < 0) && !v.sq;
    exp_mask  = acc ? (N'(1) << t) : '0;
    exp_sel   = v.sq ? m_busy : ((g >= 0) ? (N'(1) << g) : '0);
    if (hand) begin
      exp_stall = v.stall;
      exp_mask  = v.imask;
      exp_sel   = v.sel;
    end
    for (int i = 0; i < N; i++) begin
      act_mask[i] = fu_instr[i].valid;
      check($sformatf("fu_instr[%0d].pc", i), fu_instr[i].pc, v.pc);
    end
    check("issue_stall", issue_stall, exp_stall);
    check("fu_instr valid mask", act_mask, exp_mask);
    check("fu_sel", fu_sel, exp_sel);
    @(posedge clock);
    if (v.sq) begin
      m_busy = '0;
      e_cv   = 1'b0;
    end else begin
      e_cv = (g >= 0);
      if (g >= 0) begin
        e_val     = m_val[g];
        e_tag     = m_tag[g];
        m_busy[g] = 1'b0;
        m_last    = g;
      end
      if (acc) begin
        m_busy[t] = 1'b1;
        m_val[t]  = v.pc * 32'd3 + 32'd1;
        m_tag[t]  = v.pc[7:2];
      end
    end
    #1;
    check("cdb_out.valid", cdb_out.valid, hand ? v.cv : e_cv);
    if (e_cv) begin
      check("cdb_out.value", cdb_out.value, e_val);
      check("cdb_out.dest_tag", cdb_out.dest_tag, e_tag);
    end
    check("busy_cnt", busy_cnt, hand ? v.cnt : $countones(m_busy));
  endtask

  vec_t tbl [17];
  vec_t rv;

  initial begin
    // {iv, pc, cdb_ready, squash, stall, instr mask, sel, busy_cnt after, cdb valid after}
    tbl[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1, 1'b0};
    tbl[1]  = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2, 1'b0};
    tbl[2]  = '{1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2, 1'b0};
    tbl[3]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1, 1'b1};
    tbl[4]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 0, 1'b1};
    tbl[5]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 0, 1'b0};
    tbl[6]  = '{1'b1, 32'h10c, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1, 1'b0};
    tbl[7]  = '{1'b1, 32'h110, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2, 1'b0};
    tbl[8]  = '{1'b1, 32'h114, 1'b1, 1'b1, 1'b0, 2'b00, 2'b11, 0, 1'b0};
    tbl[9]  = '{1'b1, 32'h118, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1, 1'b0};
    tbl[10] = '{1'b1, 32'h11c, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 1, 1'b1};
    tbl[11] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 0, 1'b1};
    tbl[12] = '{1'b1, 32'h120, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1, 1'b0};
    tbl[13] = '{1'b1, 32'h124, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 1, 1'b1};
    tbl[14] = '{1'b1, 32'h128, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2, 1'b0};
`ifdef MEM_SCHED_RR_EN
    tbl[15] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 1, 1'b1};
    tbl[16] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 0, 1'b1};
`else
    tbl[15] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1, 1'b1};
    tbl[16] = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 0, 1'b1};
`endif

    // Reset forces combinational outputs even with hostile inputs.
    drive_issue(1'b1, 32'h200);
    cdb_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      fu_ready[i] = 1'b0;
      fu_out[i]   = '{valid: 1'b1, value: 32'hdead0000 + i, dest_tag: 6'(i)};
    end
    #2;
    check("reset issue_stall", issue_stall, 1'b0);
    check("reset fu_sel", fu_sel, '0);
    check("reset fu_instr0.valid", fu_instr[0].valid, 1'b0);
    check("reset fu_instr1.valid", fu_instr[1].valid, 1'b0);
    #10;
    check("reset cdb_out.valid", cdb_out.valid, 1'b0);
    check("reset busy_cnt", busy_cnt, 0);
    model_reset();
    apply_fu();
    drive_issue(1'b0, 32'h0);
    cdb_ready = 1'b0;
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 17; i++) step(tbl[i], 1'b1);

    // Async reset mid-burst: cdb_out holds a result, reset clears it between edges.
    rv = '{1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 0, 1'b0};
    step(rv, 1'b0);
    rv.pc = 32'h304;
    step(rv, 1'b0);
    rv = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 0, 1'b0};
    step(rv, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async reset cdb_out.valid", cdb_out.valid, 1'b0);
    check("async reset busy_cnt", busy_cnt, 0);
    check("async reset fu_sel", fu_sel, '0);
    model_reset();
    apply_fu();
    @(posedge clock);
    #3 reset = 1'b0;
    @(posedge clock);
    #1;

    for (int c = 0; c < 400; c++) begin
      rv.iv = ($urandom_range(0, 3) != 0);
      rv.pc = $urandom;
      rv.cr = ($urandom_range(0, 2) != 0);
      rv.sq = ($urandom_range(0, 19) == 0);
      step(rv, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
